// File: rtl/plot_pkg.sv
// Shared constants, FSM state type and sample clamp for the plot column scheduler.
package plot_pkg;
    localparam int HEIGHT      = 480;
    localparam int WIDTH       = 640;
    localparam int CHUNK_W     = 16;
    localparam int SAMPLE_W    = 16;
    localparam int NUM_CHUNKS  = HEIGHT / CHUNK_W;
    localparam int ROW_W       = $clog2(HEIGHT);
    localparam int CHUNK_IDX_W = 5;
    localparam int COL_W       = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        STREAM  = 2'd2,
        ADVANCE = 2'd3
    } plot_state_e;

    // Samples beyond the visible area pin to the bottom row.
    function automatic logic [ROW_W-1:0] clamp_row(input logic [SAMPLE_W-1:0] d);
        logic [ROW_W-1:0] r;
        if (d >= SAMPLE_W'(HEIGHT)) begin
            r = ROW_W'(HEIGHT - 1);
        end else begin
            r = d[ROW_W-1:0];
        end
        return r;
    endfunction
endpackage

// File: rtl/plot_column_scheduler_if.sv
// Valid/ready word stream from the column scheduler to the frame-buffer writer.
interface plot_column_scheduler_if;
    import plot_pkg::*;
    logic                   out_valid;
    logic                   out_ready;
    logic [CHUNK_W-1:0]     outputbytes;
    logic [CHUNK_IDX_W-1:0] chunk_idx;
    logic [COL_W-1:0]       Write_row;

    modport master (output out_valid, outputbytes, chunk_idx, Write_row, input out_ready);
    modport slave  (input out_valid, outputbytes, chunk_idx, Write_row, output out_ready);
endinterface

// File: rtl/plot_column_scheduler_sync.sv
// vsync_edge_sync: two-flop synchronizer for raw vsync followed by a registered rising-edge pulse.
module vsync_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_edge
);
    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_edge;

    // Synchronizer chain and one-cycle rise pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_edge <= r_sync & ~r_prev;
        end
    end

    assign o_edge = r_edge;
endmodule

// File: rtl/plot_column_scheduler.sv
// Per-frame column sequencer: one-hot column per vsync, streamed as CHUNK_W-bit words.
// Optional macro PLOT_OVERRUN_COUNT_EN adds a saturating 8-bit overrun_count output.
module plot_column_scheduler
    import plot_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vsync,
    input  logic [SAMPLE_W-1:0] data,
    output logic                busy,
    output logic                finished,
    output logic                overrun,
`ifdef PLOT_OVERRUN_COUNT_EN
    output logic [7:0]          overrun_count,
`endif
    plot_column_scheduler_if.master out_if
);
    localparam int BASE_W = ROW_W + 1;

    plot_state_e            r_state, w_state_nxt;
    logic                   r_valid, w_valid_nxt;
    logic [CHUNK_W-1:0]     r_bytes, w_bytes_nxt;
    logic [CHUNK_IDX_W-1:0] r_chunk, w_chunk_nxt;
    logic [COL_W-1:0]       r_col, w_col_nxt;
    logic [ROW_W-1:0]       r_sample, w_sample_nxt;
    logic                   r_pend, w_pend_nxt;
    logic [ROW_W-1:0]       r_pend_sample, w_pend_sample_nxt;
    logic                   r_finished, w_fin_nxt;
    logic                   r_overrun, w_ovr_nxt;
    logic                   r_busy;
    logic                   w_edge;
    logic                   w_xfer;
    logic [CHUNK_IDX_W-1:0] w_slice_idx;
    logic [BASE_W-1:0]      w_base;
    logic [CHUNK_W-1:0]     w_slice;

    vsync_edge_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (vsync),
        .o_edge  (w_edge)
    );

    assign w_xfer = r_valid & out_if.out_ready;

    // One-hot slice for the word about to be loaded: word 0 in LOAD, the next word in STREAM.
    always_comb begin
        w_slice_idx = (r_state == STREAM) ? (r_chunk + 5'd1) : 5'd0;
        w_base      = BASE_W'(w_slice_idx) * BASE_W'(CHUNK_W);
        w_slice     = '0;
        for (int j = 0; j < CHUNK_W; j++) begin
            w_slice[j] = ((w_base + BASE_W'(j)) == {1'b0, r_sample});
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_valid_nxt       = r_valid;
        w_bytes_nxt       = r_bytes;
        w_chunk_nxt       = r_chunk;
        w_col_nxt         = r_col;
        w_sample_nxt      = r_sample;
        w_pend_nxt        = r_pend;
        w_pend_sample_nxt = r_pend_sample;
        w_fin_nxt         = 1'b0;
        w_ovr_nxt         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_state_nxt  = LOAD;
                    w_sample_nxt = clamp_row(data);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOAD: begin
                w_state_nxt = STREAM;
                w_valid_nxt = 1'b1;
                w_bytes_nxt = w_slice;
                w_chunk_nxt = '0;
            end
            STREAM: begin
                if (w_xfer && (r_chunk == CHUNK_IDX_W'(NUM_CHUNKS - 1))) begin
                    w_valid_nxt = 1'b0;
                    w_fin_nxt   = 1'b1;
                    w_state_nxt = ADVANCE;
                end else if (w_xfer) begin
                    w_chunk_nxt = r_chunk + 5'd1;
                    w_bytes_nxt = w_slice;
                end else begin
                    w_state_nxt = STREAM;
                end
            end
            ADVANCE: begin
                w_col_nxt = (r_col == COL_W'(WIDTH - 1)) ? '0 : (r_col + 10'd1);
                if (r_pend) begin
                    w_state_nxt  = LOAD;
                    w_sample_nxt = r_pend_sample;
                    w_pend_nxt   = 1'b0;
                end else if (w_edge) begin
                    w_state_nxt  = LOAD;
                    w_sample_nxt = clamp_row(data);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase

        // A vsync edge while busy is deferred into the single pending slot, newest wins.
        // In ADVANCE with the slot empty the edge was already consumed straight into LOAD.
        if (w_edge && (r_state != IDLE)) begin
            w_ovr_nxt = 1'b1;
            if ((r_state == ADVANCE) && !r_pend) begin
                w_pend_nxt = 1'b0;
            end else begin
                w_pend_nxt        = 1'b1;
                w_pend_sample_nxt = clamp_row(data);
            end
        end else begin
            w_ovr_nxt = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_valid       <= 1'b0;
            r_bytes       <= '0;
            r_chunk       <= '0;
            r_col         <= '0;
            r_sample      <= '0;
            r_pend        <= 1'b0;
            r_pend_sample <= '0;
            r_finished    <= 1'b0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_valid       <= w_valid_nxt;
            r_bytes       <= w_bytes_nxt;
            r_chunk       <= w_chunk_nxt;
            r_col         <= w_col_nxt;
            r_sample      <= w_sample_nxt;
            r_pend        <= w_pend_nxt;
            r_pend_sample <= w_pend_sample_nxt;
            r_finished    <= w_fin_nxt;
            r_overrun     <= w_ovr_nxt;
            r_busy        <= (w_state_nxt != IDLE);
        end
    end

`ifdef PLOT_OVERRUN_COUNT_EN
    logic [7:0] r_ovr_cnt;

    // Saturating overrun counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr_cnt <= 8'd0;
        end else if (w_ovr_nxt && (r_ovr_cnt != 8'hFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end else begin
            r_ovr_cnt <= r_ovr_cnt;
        end
    end

    assign overrun_count = r_ovr_cnt;
`endif

    assign out_if.out_valid   = r_valid;
    assign out_if.outputbytes = r_bytes;
    assign out_if.chunk_idx   = r_chunk;
    assign out_if.Write_row   = r_col;
    assign busy               = r_busy;
    assign finished           = r_finished;
    assign overrun            = r_overrun;
endmodule

// File: tb/tb_plot_column_scheduler.sv
// Self-checking bench for plot_column_scheduler: table of sample vectors plus scoreboarded word stream.
module tb_plot_column_scheduler;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        vsync = 1'b0;
    logic [15:0] data  = 16'd0;
    logic        busy, finished, overrun;
`ifdef PLOT_OVERRUN_COUNT_EN
    logic [7:0]  overrun_count;
`endif

    plot_column_scheduler_if bus ();

    plot_column_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .vsync         (vsync),
        .data          (data),
        .busy          (busy),
        .finished      (finished),
        .overrun       (overrun),
`ifdef PLOT_OVERRUN_COUNT_EN
        .overrun_count (overrun_count),
`endif
        .out_if        (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  chunk;
        logic [9:0]  row;
        logic [15:0] word;
    } beat_t;

    typedef struct {
        logic [15:0] d;
        int          ch;
        logic [15:0] w;
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[8];
    int    tests    = 0;
    int    fails    = 0;
    int    ovr_seen = 0;
    int    exp_row  = 0;
    int    ready_mode = 0;
    bit    fin_due  = 1'b0;
    bit    hold_due = 1'b0;
    beat_t held;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Expected column: only chunk ch carries word w, all tagged with the current column.
    task automatic push_col(input int ch, input logic [15:0] w);
        beat_t b;
        for (int c = 0; c < 30; c++) begin
            b.chunk = 5'(c);
            b.row   = 10'(exp_row);
            b.word  = (c == ch) ? w : 16'h0000;
            sb.push_back(b);
        end
        exp_row = (exp_row == 639) ? 0 : exp_row + 1;
    endtask

    task automatic pulse(input logic [15:0] d, input int hi, input int lo);
        @(posedge clk);
        #1;
        data  = d;
        vsync = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        vsync = 1'b0;
        repeat (lo) @(posedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || sb.size() != 0) && n < 2000);
        check({name, "_drain_timeout"}, 32'(n >= 2000), 32'd0);
    endtask

    // out_ready driver: 0 = held high, 1 = pattern 1,0,0,1, 2 = held low.
    initial begin
        int k;
        int pat[4];
        pat = '{1, 0, 0, 1};
        k = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin
                    bus.out_ready = pat[k % 4][0];
                    k++;
                end
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pops, finished timing, stall stability, overrun counting.
    initial begin
        beat_t got, e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (fin_due || finished) begin
                    tests++;
                    if (finished !== fin_due) begin
                        fails++;
                        $display("FAIL finished: got %b want %b", finished, fin_due);
                    end
                end
                fin_due = 1'b0;
                if (overrun) ovr_seen++;
                got = {bus.chunk_idx, bus.Write_row, bus.outputbytes};
                if (hold_due && bus.out_valid) begin
                    tests++;
                    if (got !== held) begin
                        fails++;
                        $display("FAIL stall_hold: got %h want %h", got, held);
                    end
                end
                hold_due = bus.out_valid && !bus.out_ready;
                held     = got;
                if (bus.out_valid && bus.out_ready) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL extra_word: got %h want none", got);
                    end else begin
                        e = sb.pop_front();
                        if (got !== e) begin
                            fails++;
                            $display("FAIL word: got chunk %0d row %0d word %h want chunk %0d row %0d word %h",
                                     got.chunk, got.row, got.word, e.chunk, e.row, e.word);
                        end
                    end
                    if (bus.chunk_idx == 5'd29) fin_due = 1'b1;
                end
            end else begin
                fin_due  = 1'b0;
                hold_due = 1'b0;
            end
        end
    end

    initial begin
        int n;
        int ovr0;
        vecs[0] = '{16'd37,    2,  16'h0020};
        vecs[1] = '{16'd479,   29, 16'h8000};
        vecs[2] = '{16'd1000,  29, 16'h8000};
        vecs[3] = '{16'd0,     0,  16'h0001};
        vecs[4] = '{16'd15,    0,  16'h8000};
        vecs[5] = '{16'd16,    1,  16'h0001};
        vecs[6] = '{16'd480,   29, 16'h8000};
        vecs[7] = '{16'd65535, 29, 16'h8000};

        // Reset state.
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",    32'(bus.out_valid),   32'd0);
        check("rst_bytes",    32'(bus.outputbytes), 32'd0);
        check("rst_chunk",    32'(bus.chunk_idx),   32'd0);
        check("rst_row",      32'(bus.Write_row),   32'd0);
        check("rst_busy",     32'(busy),            32'd0);
        check("rst_finished", 32'(finished),        32'd0);
        check("rst_overrun",  32'(overrun),         32'd0);
`ifdef PLOT_OVERRUN_COUNT_EN
        check("rst_ovr_count", 32'(overrun_count),  32'd0);
`endif
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // First column with latency measurement from the raw vsync rise.
        push_col(2, 16'h0020);
        @(posedge clk);
        #1;
        data  = 16'd37;
        vsync = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        vsync = 1'b0;
        check("latency_in_range", 32'(n >= 5 && n <= 7), 32'd1);
        check("busy_streaming",   32'(busy),             32'd1);
        wait_idle("first");
        check("row_after_first",  32'(bus.Write_row),    32'd1);

        // Table-driven columns with out_ready held high.
        for (int i = 0; i < 8; i++) begin
            push_col(vecs[i].ch, vecs[i].w);
            pulse(vecs[i].d, 3, 3);
            wait_idle("table");
            check("table_row",  32'(bus.Write_row), 32'(exp_row));
            check("table_busy", 32'(busy),          32'd0);
        end
        check("no_overrun_yet", 32'(ovr_seen), 32'd0);

        // Stalling writer: 1,0,0,1 ready pattern.
        ready_mode = 1;
        push_col(18, 16'h1000);
        pulse(16'd300, 3, 3);
        wait_idle("stall");
        ready_mode = 0;

        // Two vsync edges during one stalled stream: second sample wins.
        ovr0 = ovr_seen;
        ready_mode = 2;
        push_col(6, 16'h0010);
        pulse(16'd100, 3, 3);
        pulse(16'd10, 3, 3);
        pulse(16'd20, 3, 3);
        push_col(1, 16'h0010);
        ready_mode = 0;
        wait_idle("double");
        check("overrun_pulses", 32'(ovr_seen - ovr0), 32'd2);
        check("double_row",     32'(bus.Write_row),   32'(exp_row));
`ifdef PLOT_OVERRUN_COUNT_EN
        check("overrun_count",  32'(overrun_count),   32'd2);
`endif

        // Asynchronous reset at chunk 12.
        push_col(12, 16'h0100);
        pulse(16'd200, 3, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.out_valid && bus.chunk_idx == 5'd12) && n < 50);
        check("reach_chunk12_timeout", 32'(n >= 50), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_row",   32'(bus.Write_row), 32'd0);
        check("midrst_busy",  32'(busy),          32'd0);
        sb.delete();
        exp_row = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push_col(12, 16'h0100);
        pulse(16'd200, 3, 3);
        wait_idle("restart");
        check("restart_row", 32'(bus.Write_row), 32'd1);

        // Write column wrap after 640 frames.
        ovr0 = ovr_seen;
        #2 rst_n = 1'b0;
        sb.delete();
        exp_row = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int f = 0; f < 639; f++) begin
            push_col(0, 16'h0020);
            pulse(16'd5, 2, 2);
            wait_idle("wrap");
        end
        check("row_639", 32'(bus.Write_row), 32'd639);
        push_col(0, 16'h0020);
        pulse(16'd5, 2, 2);
        wait_idle("wrap_last");
        check("row_wrapped",      32'(bus.Write_row),   32'd0);
        check("wrap_no_overrun",  32'(ovr_seen - ovr0), 32'd0);
        check("sb_empty",         32'(sb.size()),       32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/plot_column_scheduler.md
Name: plot_column_scheduler

Overview:
- Per-frame sequencer for the VGA plot path.
- On each vsync it captures one sample value and expands it into a one-hot HEIGHT-bit column, bit (sample) set and all others clear.
- It streams that column as CHUNK_W-bit words over a valid/ready interface to the frame-buffer writer, tagged with chunk index and write column.
- It owns the write-column pointer (scrolling plot) and reports overruns when a new vsync arrives before the previous column has drained.

Parameters:
- HEIGHT, 480, visible rows; number of bits in one column.
- WIDTH, 640, visible columns; write-column wrap point.
- CHUNK_W, 16, bits per output word; HEIGHT must be a multiple of CHUNK_W.
- SAMPLE_W, 16, width of the incoming sample.
- NUM_CHUNKS (localparam), HEIGHT/CHUNK_W = 30, words per column.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- vsync  in  1  raw vertical sync, asynchronous to clk
- data  in  SAMPLE_W  sample value (row index), sampled on the detected vsync edge
- out_ready  in  1  writer accepts the word when high with out_valid
- out_valid  out  1  outputbytes/chunk_idx/Write_row valid
- outputbytes  out  CHUNK_W  column word; bit j = row chunk_idx*CHUNK_W+j
- chunk_idx  out  5  word index 0..NUM_CHUNKS-1
- Write_row  out  10  destination column 0..WIDTH-1
- busy  out  1  high from capture until the last word is accepted
- finished  out  1  one-cycle pulse when the last word is accepted
- overrun  out  1  one-cycle pulse when a vsync edge is dropped or deferred

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; Write_row = 0; pending flag clear.
- vsync handling: 2-flop synchronizer, then rising-edge detect. Edge is seen 3 clk after the raw rise, give or take one cycle.
- Capture: on the edge cycle, latch data. If data >= HEIGHT, clamp to HEIGHT-1.
- FSM states: IDLE, LOAD, STREAM, ADVANCE.
- IDLE: on edge -> LOAD (latch sample).
- LOAD: build word 0 combinationally from the sample; assert out_valid next cycle. Enter STREAM with chunk_idx = 0.
- STREAM:
  - outputbytes = one-hot slice: bit j is set iff chunk_idx*CHUNK_W + j == sample.
  - Handshake transfers when out_valid && out_ready.
  - Outputs hold stable while out_valid is high and out_ready is low.
  - On transfer with chunk_idx < NUM_CHUNKS-1: increment chunk_idx. The next word is valid the following cycle; back-to-back transfers are allowed, 1 word/clk.
  - On transfer of the last word: drop out_valid, pulse finished, go to ADVANCE.
- ADVANCE (1 cycle): Write_row = (Write_row == WIDTH-1) ? 0 : Write_row+1. Then:
  - if pending: LOAD using the pending sample, clear pending;
  - else: IDLE.
- busy = state != IDLE.
- Edge while busy:
  - pending empty: store data in the pending register, set pending, pulse overrun.
  - pending full: overwrite the pending sample (newest wins), pulse overrun.
- Edge in the same cycle as the last-word transfer: treated as busy; goes to pending, overrun pulses.
- Latency: edge to first out_valid = 2 clk. A full column with out_ready held high = NUM_CHUNKS cycles.
- Async reset mid-stream: out_valid drops immediately, column is abandoned, Write_row returns to 0, pending clears.
- No combinational path from out_ready to out_valid.

Optional Feature:
- Macro: PLOT_OVERRUN_COUNT_EN.
- Defined:
  - adds output overrun_count, 8 bits;
  - saturating count of overrun pulses, holds at 255;
  - cleared only by reset.
- Undefined: port absent, no counter logic; overrun pulse unchanged.

Decomposition:
- Shared package plot_pkg holds:
  - HEIGHT, WIDTH, CHUNK_W, NUM_CHUNKS constants;
  - FSM state enum (IDLE, LOAD, STREAM, ADVANCE);
  - the clamp function.
- One sub-module, vsync_edge_sync: 2-flop synchronizer plus rising-edge pulse, reset by rst_n.
- The one-hot slice generator stays inline.

Test Plan:
- Reset, then vsync edge with data = 37, out_ready = 1:
  - 30 words;
  - only word 2 nonzero, equal to 0x0020;
  - finished pulses on word 29;
  - Write_row becomes 1.
- data = 479 → word 29 = 0x8000, all others 0. data = 1000 → identical to 479 (clamp).
- out_ready toggling 1,0,0,1 during the stream → outputbytes and chunk_idx stable while stalled; no word skipped or duplicated.
- Two vsync edges during one stream with data 10 then 20:
  - two overrun pulses;
  - next column has bit 20 set (word 1 = 0x0010);
  - PLOT_OVERRUN_COUNT_EN build: overrun_count = 2.
- 640 consecutive frames → Write_row wraps from 639 to 0.
- rst_n low at chunk_idx = 12 → out_valid = 0 in the same cycle, Write_row = 0; next vsync restarts at chunk 0.
